// File: rtl/cam_pkg.sv
// Shared state encoding and QCIF frame constants for the camera capture sequencer.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } cam_state_t;

    localparam int QCIF_H = 176;
    localparam int QCIF_V = 144;

endpackage

// File: rtl/cam_edge_det.sv
// Registered rise/fall detector for a signal already synchronous to clk.
module cam_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q;

    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

    assign rise = ~q & d;
    assign fall = q & ~d;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: VSYNC/HREF framing, X/Y address generation, framebuffer write strobe.
// Define CAM_CTRL_CONTINUOUS_EN to re-arm after every frame instead of single-shot capture.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_PIXELS = QCIF_H,
    parameter int V_LINES  = QCIF_V,
    parameter int X_W      = 8,
    parameter int Y_W      = 8
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           VSYNC,
    input  logic           HREF,
    input  logic           PIX_VALID,
    input  logic [7:0]     PIX_IN,
    input  logic           CAPTURE_REQ,
    output logic           W_EN,
    output logic [X_W-1:0] X_ADDR,
    output logic [Y_W-1:0] Y_ADDR,
    output logic [7:0]     PIX_OUT,
    output logic           BUSY,
    output logic           FRAME_DONE
);

    // One extra bit so the counters can sit at the limit without wrapping.
    localparam logic [X_W:0] H_MAX = (X_W+1)'(H_PIXELS);
    localparam logic [Y_W:0] V_MAX = (Y_W+1)'(V_LINES);

    cam_state_t state, state_n;
    logic [X_W:0] x;
    logic [Y_W:0] y;
    logic vs_rise, vs_fall, href_fall, href_rise_unused;
    logic pix_ok;

    cam_edge_det u_vs_edge (
        .clk  (CLK),
        .rst  (RESET),
        .d    (VSYNC),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    cam_edge_det u_href_edge (
        .clk  (CLK),
        .rst  (RESET),
        .d    (HREF),
        .rise (href_rise_unused),
        .fall (href_fall)
    );

    assign pix_ok = (state == ACTIVE) & PIX_VALID & HREF & ~VSYNC & (x < H_MAX) & (y < V_MAX);

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        BUSY       = 1'b0;
        FRAME_DONE = 1'b0;
        case (state)
            IDLE: begin
                if (CAPTURE_REQ) state_n = ARMED;
            end
            ARMED: begin
                BUSY = 1'b1;
                if (vs_fall) state_n = ACTIVE;
            end
            ACTIVE: begin
                BUSY = 1'b1;
                if (vs_rise) state_n = DONE;
            end
            DONE: begin
                FRAME_DONE = 1'b1;
`ifdef CAM_CTRL_CONTINUOUS_EN
                state_n = ARMED;
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x       <= '0;
            y       <= '0;
            W_EN    <= 1'b0;
            X_ADDR  <= '0;
            Y_ADDR  <= '0;
            PIX_OUT <= '0;
        end else begin
            W_EN <= pix_ok;
            if (pix_ok) begin
                X_ADDR  <= x[X_W-1:0];
                Y_ADDR  <= y[Y_W-1:0];
                PIX_OUT <= PIX_IN;
            end
            if (state == ARMED && vs_fall) begin
                x <= '0;
                y <= '0;
            end else if (state == ACTIVE) begin
                // Line end wins over the increment; a pixel on the same cycle already used the old x.
                if (href_fall && x != '0) begin
                    x <= '0;
                    if (y < V_MAX) y <= y + 1'b1;
                end else if (pix_ok) begin
                    x <= x + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed scoreboard bench for cam_capture_ctrl with a 4x3 frame.
module tb_cam_capture_ctrl;

    localparam int H = 4;
    localparam int V = 3;
`ifdef CAM_CTRL_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET, VSYNC, HREF, PIX_VALID, CAPTURE_REQ;
    logic [7:0] PIX_IN;
    logic       W_EN, BUSY, FRAME_DONE;
    logic [7:0] X_ADDR, Y_ADDR, PIX_OUT;

    cam_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .X_W(8), .Y_W(8)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .VSYNC       (VSYNC),
        .HREF        (HREF),
        .PIX_VALID   (PIX_VALID),
        .PIX_IN      (PIX_IN),
        .CAPTURE_REQ (CAPTURE_REQ),
        .W_EN        (W_EN),
        .X_ADDR      (X_ADDR),
        .Y_ADDR      (Y_ADDR),
        .PIX_OUT     (PIX_OUT),
        .BUSY        (BUSY),
        .FRAME_DONE  (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] pix;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write is matched against the oldest expected pixel, including its cycle.
    always @(negedge CLK) begin
        if (FRAME_DONE === 1'b1) done_cnt++;
        if (W_EN !== 1'b0) begin
            chk("unexpected_wen", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("wen_val", 32'(W_EN), 32'd1);
                chk("x_addr", 32'(X_ADDR), 32'(e.x));
                chk("y_addr", 32'(Y_ADDR), 32'(e.y));
                chk("pix_out", 32'(PIX_OUT), 32'(e.pix));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        tick(1);
    endtask

    task automatic req();
        CAPTURE_REQ = 1'b1;
        tick(1);
        CAPTURE_REQ = 1'b0;
    endtask

    task automatic frame_start();
        VSYNC = 1'b1;
        tick(3);
        VSYNC = 1'b0;
        tick(2);
    endtask

    task automatic frame_end();
        VSYNC = 1'b1;
        tick(4);
    endtask

    // Pixel i of line y lands at (i,y) only if captured and inside the frame.
    task automatic send_line(input int y, input int npix, input bit cap);
        HREF = 1'b1;
        tick(1);
        for (int i = 0; i < npix; i++) begin
            PIX_VALID = 1'b1;
            PIX_IN    = 8'($urandom);
            if (cap && i < H && y < V) sb.push_back('{x: i, y: y, pix: PIX_IN, cyc: cyc + 1});
            tick(1);
            PIX_VALID = 1'b0;
            tick(1);
        end
        HREF = 1'b0;
        tick(3);
    endtask

    task automatic frame(input int nl, input int np, input bit cap);
        frame_start();
        for (int l = 0; l < nl; l++) send_line(l, np, cap);
        frame_end();
    endtask

    initial begin
        int d0;
        RESET = 1'b1; VSYNC = 1'b0; HREF = 1'b0; PIX_VALID = 1'b0;
        PIX_IN = 8'h00; CAPTURE_REQ = 1'b0;
        tick(3);
        chk("rst_wen", 32'(W_EN), 0);
        chk("rst_x", 32'(X_ADDR), 0);
        chk("rst_y", 32'(Y_ADDR), 0);
        chk("rst_pix", 32'(PIX_OUT), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(FRAME_DONE), 0);
        RESET = 1'b0;
        tick(2);

        // Basic 4x3 frame
        req();
        chk("busy_armed", 32'(BUSY), 1);
        d0 = done_cnt;
        frame(3, 4, 1'b1);
        chk("basic_done", 32'(done_cnt - d0), 1);
        chk("basic_missing", 32'(sb.size()), 0);
        chk("basic_busy_after", 32'(BUSY), 32'(CONT));

        // Overlong lines
        do_reset();
        req();
        d0 = done_cnt;
        frame(3, 6, 1'b1);
        chk("long_done", 32'(done_cnt - d0), 1);
        chk("long_missing", 32'(sb.size()), 0);

        // Extra lines beyond V
        do_reset();
        req();
        d0 = done_cnt;
        frame(5, 4, 1'b1);
        chk("extra_done", 32'(done_cnt - d0), 1);
        chk("extra_missing", 32'(sb.size()), 0);

        // Request after the frame already opened, then a request while active
        do_reset();
        d0 = done_cnt;
        frame_start();
        send_line(0, 4, 1'b0);
        req();
        chk("mid_busy", 32'(BUSY), 1);
        send_line(1, 4, 1'b0);
        send_line(2, 4, 1'b0);
        frame_end();
        chk("mid_no_done", 32'(done_cnt - d0), 0);
        frame_start();
        send_line(0, 4, 1'b1);
        req();
        send_line(1, 4, 1'b1);
        send_line(2, 4, 1'b1);
        frame_end();
        chk("mid_done", 32'(done_cnt - d0), 1);
        frame(3, 4, CONT);
        chk("mid_ignored_req", 32'(done_cnt - d0), CONT ? 2 : 1);
        chk("mid_missing", 32'(sb.size()), 0);

        // Reset in the middle of line 1
        do_reset();
        req();
        d0 = done_cnt;
        frame_start();
        send_line(0, 4, 1'b1);
        HREF = 1'b1;
        tick(1);
        for (int i = 0; i < 2; i++) begin
            PIX_VALID = 1'b1;
            PIX_IN    = 8'($urandom);
            sb.push_back('{x: i, y: 1, pix: PIX_IN, cyc: cyc + 1});
            tick(1);
        end
        PIX_IN = 8'hA5;
        RESET  = 1'b1;
        tick(1);
        chk("mrst_wen", 32'(W_EN), 0);
        chk("mrst_x", 32'(X_ADDR), 0);
        chk("mrst_y", 32'(Y_ADDR), 0);
        chk("mrst_pix", 32'(PIX_OUT), 0);
        chk("mrst_busy", 32'(BUSY), 0);
        RESET = 1'b0;
        tick(1);
        PIX_VALID = 1'b0;
        tick(2);
        HREF = 1'b0;
        tick(3);
        send_line(2, 4, 1'b0);
        frame_end();
        chk("mrst_no_done", 32'(done_cnt - d0), 0);
        frame(3, 4, 1'b0);
        chk("mrst_stays_idle", 32'(done_cnt - d0), 0);
        chk("mrst_missing", 32'(sb.size()), 0);

        // One request, three frames
        do_reset();
        req();
        d0 = done_cnt;
        for (int f = 0; f < 3; f++) frame(3, 4, (f == 0) || CONT);
        chk("cont_done", 32'(done_cnt - d0), CONT ? 3 : 1);
        chk("cont_missing", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
